// File: rtl/obj_list_reader.sv
`default_nettype none
// ============================================================================
//  Module      : obj_list_reader
//  Description : Per-scanline walker of the object RAM; decodes each sprite
//                entry and emits visible ones as descriptors over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module obj_list_reader #(
    parameter int NUM_ENTRIES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        start,
    input  logic [8:0]  line,
    input  logic        dma_busy,
    output logic [9:0]  obj_addr,
    input  logic [15:0] obj_din,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [9:0]  desc_x,
    output logic [8:0]  desc_y,
    output logic [6:0]  desc_row,
    output logic [15:0] desc_code,
    output logic [6:0]  desc_color,
    output logic        desc_pri,
    output logic        desc_flipx,
    output logic        desc_flipy,
    output logic [1:0]  desc_w,
    output logic [1:0]  desc_h,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] c_LAST_IDX = 8'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD0   = 3'd1,
        S_RD1   = 3'd2,
        S_RD2   = 3'd3,
        S_RD3   = 3'd4,
        S_CAP   = 3'd5,
        S_CHECK = 3'd6,
        S_EMIT  = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_idx;
    logic [7:0]  w_idx_nxt;
    logic [8:0]  r_line;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_latch_line;
    logic        w_load_desc;
    logic        w_advance;
    logic [1:0]  w_word_sel;
    logic [15:0] r_w0;
    logic [15:0] r_w1;
    logic [15:0] r_w2;
    logic [15:0] r_w3;
    logic [8:0]  w_row;
    logic [8:0]  w_rows;
    logic        w_empty;
    logic        w_visible;

    logic [9:0]  r_desc_x;
    logic [8:0]  r_desc_y;
    logic [6:0]  r_desc_row;
    logic [15:0] r_desc_code;
    logic [6:0]  r_desc_color;
    logic        r_desc_pri;
    logic        r_desc_flipx;
    logic        r_desc_flipy;
    logic [1:0]  r_desc_w;
    logic [1:0]  r_desc_h;

    // Entry decode; all arithmetic wraps at 9 bits so sprites straddle line 0.
    assign w_row     = r_line - r_w0[8:0];
    assign w_rows    = 9'd16 << r_w0[12:11];
    assign w_visible = (w_row < w_rows);
    assign w_empty   = ~|{r_w0, r_w1, r_w2, r_w3};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_done_nxt   = 1'b0;
        w_latch_line = 1'b0;
        w_load_desc  = 1'b0;
        w_advance    = 1'b0;

        case (r_state)
            S_IDLE:  w_state_nxt = r_state;
            S_RD0:   w_state_nxt = dma_busy ? S_RD0 : S_RD1;
            S_RD1:   w_state_nxt = dma_busy ? S_RD0 : S_RD2;
            S_RD2:   w_state_nxt = dma_busy ? S_RD0 : S_RD3;
            S_RD3:   w_state_nxt = dma_busy ? S_RD0 : S_CAP;
            S_CAP:   w_state_nxt = dma_busy ? S_RD0 : S_CHECK;
            S_CHECK: begin
                if (!w_empty && w_visible) begin
                    w_load_desc = 1'b1;
                    w_state_nxt = S_EMIT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_EMIT:  w_advance = desc_ready;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_advance) begin
            if (r_idx == c_LAST_IDX) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end else begin
                w_idx_nxt   = r_idx + 8'd1;
                w_state_nxt = S_RD0;
            end
        end

        // A new start overrides everything, including a pending completion.
        if (start) begin
            w_state_nxt  = S_RD0;
            w_idx_nxt    = 8'd0;
            w_done_nxt   = 1'b0;
            w_latch_line = 1'b1;
            w_load_desc  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx        <= 8'd0;
            r_line       <= 9'd0;
            r_done       <= 1'b0;
            r_w0         <= 16'd0;
            r_w1         <= 16'd0;
            r_w2         <= 16'd0;
            r_w3         <= 16'd0;
            r_desc_x     <= 10'd0;
            r_desc_y     <= 9'd0;
            r_desc_row   <= 7'd0;
            r_desc_code  <= 16'd0;
            r_desc_color <= 7'd0;
            r_desc_pri   <= 1'b0;
            r_desc_flipx <= 1'b0;
            r_desc_flipy <= 1'b0;
            r_desc_w     <= 2'd0;
            r_desc_h     <= 2'd0;
        end else if (ce) begin
            r_idx  <= w_idx_nxt;
            r_done <= w_done_nxt;
            if (w_latch_line) begin
                r_line <= line;
            end
            // RAM data lags the address by one cycle, so state k captures word k-1.
            case (r_state)
                S_RD1:   r_w0 <= obj_din;
                S_RD2:   r_w1 <= obj_din;
                S_RD3:   r_w2 <= obj_din;
                S_CAP:   r_w3 <= obj_din;
                default: ;
            endcase
            if (w_load_desc) begin
                r_desc_x     <= r_w3[9:0];
                r_desc_y     <= r_w0[8:0];
                r_desc_row   <= w_row[6:0];
                r_desc_code  <= r_w1;
                r_desc_color <= r_w2[6:0];
                r_desc_pri   <= r_w2[7];
                r_desc_flipx <= r_w2[8];
                r_desc_flipy <= r_w2[9];
                r_desc_w     <= r_w0[14:13];
                r_desc_h     <= r_w0[12:11];
            end
        end
    end

    always_comb begin
        w_word_sel = 2'd0;
        case (r_state)
            S_RD1:        w_word_sel = 2'd1;
            S_RD2:        w_word_sel = 2'd2;
            S_RD3, S_CAP: w_word_sel = 2'd3;
            default:      w_word_sel = 2'd0;
        endcase
    end

    assign obj_addr   = {r_idx, w_word_sel};
    assign desc_valid = (r_state == S_EMIT);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

    assign desc_x     = r_desc_x;
    assign desc_y     = r_desc_y;
    assign desc_row   = r_desc_row;
    assign desc_code  = r_desc_code;
    assign desc_color = r_desc_color;
    assign desc_pri   = r_desc_pri;
    assign desc_flipx = r_desc_flipx;
    assign desc_flipy = r_desc_flipy;
    assign desc_w     = r_desc_w;
    assign desc_h     = r_desc_h;

endmodule
`default_nettype wire
